// File: rtl/panel_write_arbiter.sv
// panel_write_arbiter: shares the framebuffer write port between a buffered UDP writer and a local valid/ready master, and sequences buffer swaps
module panel_write_arbiter #(
   parameter int FIFO_DEPTH = 8,
   parameter int URGENT_LVL = FIFO_DEPTH - 2
) (
   input  logic                          clock,
   input  logic                          reset,
   input  logic [5:0]                    a_en,
   input  logic [3:0]                    a_wr,
   input  logic [15:0]                   a_addr,
   input  logic [23:0]                   a_wdat,
   input  logic                          b_valid,
   output logic                          b_ready,
   input  logic [5:0]                    b_en,
   input  logic [3:0]                    b_wr,
   input  logic [15:0]                   b_addr,
   input  logic [23:0]                   b_wdat,
   input  logic                          fb_busy,
   input  logic                          swap_req,
   output logic                          swap_done,
   output logic                          buf_sel,
   output logic [5:0]                    ctrl_en,
   output logic [3:0]                    ctrl_wr,
   output logic [15:0]                   ctrl_addr,
   output logic [23:0]                   ctrl_wdat,
   output logic                          ctrl_bank,
   output logic                          overflow,
   output logic [15:0]                   drop_count,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int LW = PW + 1;
   localparam logic [LW-1:0] FULL_LVL = LW'(FIFO_DEPTH);
   localparam logic [LW-1:0] URG_LVL = LW'(URGENT_LVL);

   typedef enum logic {IDLE, PENDING} state_t;

   logic [49:0]   mem_q [FIFO_DEPTH];
   logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [LW-1:0] level_q, level_d;
   logic          pref_a_q, pref_a_d;
   state_t        state_q, state_d;
   logic          buf_sel_q, buf_sel_d, swap_done_q, swap_done_d;
   logic          overflow_q, overflow_d;
   logic [15:0]   drop_count_q, drop_count_d;
   logic [5:0]    ctrl_en_q, ctrl_en_d;
   logic [43:0]   ctrl_fld_q, ctrl_fld_d;
   logic          ctrl_bank_q, ctrl_bank_d;
   logic          a_req, a_elig, b_elig, urgent, grant_a, grant_b, push, drop, swap_exit;
   logic [49:0]   head;

   // grant decision: urgency override, then round-robin, B blocked while a swap waits
   always_comb begin
      a_req   = |a_en;
      a_elig  = level_q != '0;
      b_elig  = b_valid && state_q == IDLE;
      urgent  = a_elig && level_q >= URG_LVL;
      grant_a = !reset && !fb_busy && a_elig && (urgent || !b_elig || pref_a_q);
      grant_b = !reset && !fb_busy && b_elig && !grant_a;
      push    = a_req && (level_q != FULL_LVL || grant_a);
      drop    = a_req && !push;
      b_ready = grant_b;
      head    = mem_q[rd_ptr_q];
   end

   // FIFO pointers, occupancy, round-robin pointer and drop accounting
   always_comb begin
      wr_ptr_d     = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
      rd_ptr_d     = grant_a ? rd_ptr_q + PW'(1) : rd_ptr_q;
      level_d      = level_q + LW'(push) - LW'(grant_a);
      pref_a_d     = grant_a ? 1'b0 : grant_b ? 1'b1 : pref_a_q;
      overflow_d   = overflow_q | drop;
      drop_count_d = (drop && drop_count_q != 16'hFFFF) ? drop_count_q + 16'd1 : drop_count_q;
   end

   // swap sequencing: wait until every queued and in-flight UDP write has been issued
   always_comb begin
      swap_exit   = state_q == PENDING && level_q == '0 && !a_req && !grant_a;
      state_d     = state_q == IDLE ? (swap_req ? PENDING : IDLE) : (swap_exit ? IDLE : PENDING);
      buf_sel_d   = buf_sel_q ^ swap_exit;
      swap_done_d = swap_exit;
   end

   // write port payload: pulse enable on a grant, hold the other fields otherwise
   always_comb begin
      ctrl_en_d   = grant_a ? head[49:44] : grant_b ? b_en : 6'd0;
      ctrl_fld_d  = grant_a ? head[43:0] : grant_b ? {b_wr, b_addr, b_wdat} : ctrl_fld_q;
      ctrl_bank_d = (grant_a || grant_b) ? !buf_sel_q : ctrl_bank_q;
   end

   // FIFO storage, written on every accepted push
   always_ff @(posedge clock) begin
      if (push) mem_q[wr_ptr_q] <= {a_en, a_wr, a_addr, a_wdat};
   end

   // state registers
   always_ff @(posedge clock) begin
      if (reset) begin
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         level_q      <= '0;
         pref_a_q     <= 1'b1;
         state_q      <= IDLE;
         buf_sel_q    <= 1'b0;
         swap_done_q  <= 1'b0;
         overflow_q   <= 1'b0;
         drop_count_q <= '0;
         ctrl_en_q    <= '0;
         ctrl_fld_q   <= '0;
         ctrl_bank_q  <= 1'b0;
      end else begin
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         level_q      <= level_d;
         pref_a_q     <= pref_a_d;
         state_q      <= state_d;
         buf_sel_q    <= buf_sel_d;
         swap_done_q  <= swap_done_d;
         overflow_q   <= overflow_d;
         drop_count_q <= drop_count_d;
         ctrl_en_q    <= ctrl_en_d;
         ctrl_fld_q   <= ctrl_fld_d;
         ctrl_bank_q  <= ctrl_bank_d;
      end
   end

   assign {ctrl_wr, ctrl_addr, ctrl_wdat} = ctrl_fld_q;
   assign ctrl_en    = ctrl_en_q;
   assign ctrl_bank  = ctrl_bank_q;
   assign buf_sel    = buf_sel_q;
   assign swap_done  = swap_done_q;
   assign overflow   = overflow_q;
   assign drop_count = drop_count_q;
   assign fifo_level = level_q;
endmodule
